// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pic_pkg
// Description : Shared types and geometry helpers for the picture position
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

    typedef enum logic [1:0] {
        STOP   = 2'd0,
        AUTO   = 2'd1,
        MANUAL = 2'd2
    } pic_mode_t;

    function automatic int calc_limit(input int vis_size, input int pic_size);
        return vis_size - pic_size;
    endfunction

    function automatic int calc_center(input int vis_size, input int pic_size);
        return (vis_size - pic_size) / 2;
    endfunction

    function automatic pic_mode_t mode_decode(input logic run, input logic manual);
        if (!run)
            return STOP;
        else if (manual)
            return MANUAL;
        else
            return AUTO;
    endfunction

    localparam int c_XMAX_DEFAULT = calc_limit(640, 100);
    localparam int c_YMAX_DEFAULT = calc_limit(480, 100);
    localparam int c_XRST_DEFAULT = calc_center(640, 100);
    localparam int c_YRST_DEFAULT = calc_center(480, 100);

endpackage
`default_nettype wire

// File: rtl/pic_axis.sv
`default_nettype none
// ============================================================================
// Module      : pic_axis
// Description : One coordinate of the picture position: auto edge bounce or
//               clamped manual stepping, applied on each update strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_axis
    import pic_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int LIMIT     = 540,
    parameter int STEP      = 2,
    parameter int RESET_VAL = 270
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd,
    input  pic_mode_t        mode,
    input  logic             inc_req,
    input  logic             dec_req,
    output logic [WIDTH-1:0] pos,
    output logic             dir
);

    localparam int               c_WIDE    = WIDTH + 1;
    localparam logic [WIDTH:0]   c_STEP_W  = c_WIDE'(STEP);
    localparam logic [WIDTH:0]   c_LIMIT_W = c_WIDE'(LIMIT);
    localparam logic [WIDTH-1:0] c_STEP    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] c_LIMIT   = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] c_RESET   = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_pos;
    logic             r_dir;
    logic [WIDTH:0]   w_sum;
    logic             w_high_hit;
    logic             w_low_hit;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_down;
    logic [WIDTH-1:0] w_pos_nxt;
    logic             w_dir_nxt;

    // Limit tests are done one bit wider so pos+STEP never wraps before clamping.
    always_comb begin
        w_sum      = {1'b0, r_pos} + c_STEP_W;
        w_high_hit = (w_sum >= c_LIMIT_W);
        w_low_hit  = ({1'b0, r_pos} <= c_STEP_W);
        w_up       = w_high_hit ? c_LIMIT : w_sum[WIDTH-1:0];
        w_down     = w_low_hit ? '0 : (r_pos - c_STEP);
        w_pos_nxt  = r_pos;
        w_dir_nxt  = r_dir;
        if (upd) begin
            case (mode)
                AUTO: begin
                    if (r_dir) begin
                        w_pos_nxt = w_up;
                        if (w_high_hit)
                            w_dir_nxt = 1'b0;
                    end else begin
                        w_pos_nxt = w_down;
                        if (w_low_hit)
                            w_dir_nxt = 1'b1;
                    end
                end
                MANUAL: begin
                    if (inc_req && !dec_req)
                        w_pos_nxt = w_up;
                    else if (dec_req && !inc_req)
                        w_pos_nxt = w_down;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos <= c_RESET;
            r_dir <= 1'b1;
        end else begin
            r_pos <= w_pos_nxt;
            r_dir <= w_dir_nxt;
        end
    end

    assign pos = r_pos;
    assign dir = r_dir;

endmodule
`default_nettype wire

// File: rtl/pic_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pic_pos_ctrl
// Description : Frame-synchronous picture position controller (stop / auto
//               bounce / manual buttons), updating only at vsync rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_pos_ctrl
    import pic_pkg::*;
#(
    parameter int pichsize  = 100,
    parameter int picvsize  = 100,
    parameter int h_size    = 640,
    parameter int v_size    = 480,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vsync,
    input  logic                      run,
    input  logic                      manual,
    input  logic                      btn_l,
    input  logic                      btn_r,
    input  logic                      btn_u,
    input  logic                      btn_d,
    output logic [$clog2(h_size)-1:0] inith_addr,
    output logic [$clog2(v_size)-1:0] initv_addr,
    output logic                      frame_tick,
    output logic                      dir_x,
    output logic                      dir_y
);

    localparam int               c_HW       = $clog2(h_size);
    localparam int               c_VW       = $clog2(v_size);
    localparam int               c_XMAX     = calc_limit(h_size, pichsize);
    localparam int               c_YMAX     = calc_limit(v_size, picvsize);
    localparam int               c_XRST     = calc_center(h_size, pichsize);
    localparam int               c_YRST     = calc_center(v_size, picvsize);
    localparam int               c_DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(FRAME_DIV - 1);

    logic               r_vsync_q;
    logic               r_frame_tick;
    logic [c_DIV_W-1:0] r_div_cnt;
    pic_mode_t          r_mode;
    pic_mode_t          w_mode_nxt;
    logic               r_req_l, r_req_r, r_req_u, r_req_d;
    logic               w_req_l, w_req_r, w_req_u, w_req_d;
    logic               w_tick;
    logic               w_upd;

    assign w_tick = vsync & ~r_vsync_q;
    assign w_upd  = w_tick && (r_div_cnt == c_DIV_LAST);

    // vsync_q resets high so a vsync already high at release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_q    <= 1'b1;
            r_frame_tick <= 1'b0;
            r_div_cnt    <= '0;
        end else begin
            r_vsync_q    <= vsync;
            r_frame_tick <= w_tick;
            if (w_tick)
                r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + c_DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_l <= 1'b0;
            r_req_r <= 1'b0;
            r_req_u <= 1'b0;
            r_req_d <= 1'b0;
        end else if (w_tick) begin
            r_req_l <= 1'b0;
            r_req_r <= 1'b0;
            r_req_u <= 1'b0;
            r_req_d <= 1'b0;
        end else begin
            r_req_l <= r_req_l | btn_l;
            r_req_r <= r_req_r | btn_r;
            r_req_u <= r_req_u | btn_u;
            r_req_d <= r_req_d | btn_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_mode <= STOP;
        else
            r_mode <= w_mode_nxt;
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (w_tick)
            w_mode_nxt = mode_decode(run, manual);
    end

    // Buttons seen in the tick cycle itself count toward this update.
    always_comb begin
        w_req_l = r_req_l | btn_l;
        w_req_r = r_req_r | btn_r;
        w_req_u = r_req_u | btn_u;
        w_req_d = r_req_d | btn_d;
    end

    pic_axis #(
        .WIDTH     (c_HW),
        .LIMIT     (c_XMAX),
        .STEP      (STEP),
        .RESET_VAL (c_XRST)
    ) u_axis_x (
        .clk     (clk),
        .rst     (rst),
        .upd     (w_upd),
        .mode    (w_mode_nxt),
        .inc_req (w_req_r),
        .dec_req (w_req_l),
        .pos     (inith_addr),
        .dir     (dir_x)
    );

    pic_axis #(
        .WIDTH     (c_VW),
        .LIMIT     (c_YMAX),
        .STEP      (STEP),
        .RESET_VAL (c_YRST)
    ) u_axis_y (
        .clk     (clk),
        .rst     (rst),
        .upd     (w_upd),
        .mode    (w_mode_nxt),
        .inc_req (w_req_d),
        .dec_req (w_req_u),
        .pos     (initv_addr),
        .dir     (dir_y)
    );

    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_pic_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pic_pos_ctrl
// Description : Directed self-checking bench for pic_pos_ctrl using three
//               instances (default, small 16x16 geometry, FRAME_DIV=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pic_pos_ctrl;

    logic clk = 1'b0;
    logic rst, vsync;
    logic run_a, manual_a;
    logic run_b, manual_b, bl_b, br_b, bu_b, bd_b;
    logic zero;

    logic [9:0] ax, cx;
    logic [8:0] ay, cy;
    logic [3:0] bx, by;
    logic aft, adx, ady, bft, bdx, bdy, cft, cdx, cdy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pic_pos_ctrl u_dut_a (
        .clk(clk), .rst(rst), .vsync(vsync), .run(run_a), .manual(manual_a),
        .btn_l(zero), .btn_r(zero), .btn_u(zero), .btn_d(zero),
        .inith_addr(ax), .initv_addr(ay), .frame_tick(aft), .dir_x(adx), .dir_y(ady)
    );

    pic_pos_ctrl #(
        .pichsize(5), .picvsize(5), .h_size(16), .v_size(16), .STEP(2), .FRAME_DIV(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .vsync(vsync), .run(run_b), .manual(manual_b),
        .btn_l(bl_b), .btn_r(br_b), .btn_u(bu_b), .btn_d(bd_b),
        .inith_addr(bx), .initv_addr(by), .frame_tick(bft), .dir_x(bdx), .dir_y(bdy)
    );

    pic_pos_ctrl #(.FRAME_DIV(3)) u_dut_c (
        .clk(clk), .rst(rst), .vsync(vsync), .run(run_a), .manual(manual_a),
        .btn_l(zero), .btn_r(zero), .btn_u(zero), .btn_d(zero),
        .inith_addr(cx), .initv_addr(cy), .frame_tick(cft), .dir_x(cdx), .dir_y(cdy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Ends one cycle after the edge that registers the tick.
    task automatic vsync_pulse;
        vsync = 1'b0;
        step;
        step;
        vsync = 1'b1;
        step;
    endtask

    task automatic press_b(input logic l, input logic r, input logic u, input logic d);
        bl_b = l; br_b = r; bu_b = u; bd_b = d;
        step;
        bl_b = 1'b0; br_b = 1'b0; bu_b = 1'b0; bd_b = 1'b0;
        step;
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1; zero = 1'b0;
        run_a = 1'b0; manual_a = 1'b0;
        run_b = 1'b0; manual_b = 1'b0;
        bl_b = 1'b0; br_b = 1'b0; bu_b = 1'b0; bd_b = 1'b0;
        repeat (3) step;
        rst = 1'b0;

        check("rst_ax", ax, 270);
        check("rst_ay", ay, 190);
        check("rst_adx", adx, 1);
        check("rst_ady", ady, 1);
        check("rst_bx", bx, 5);
        check("rst_by", by, 5);
        for (int i = 0; i < 10; i++) begin
            step;
            check("idle_aft", aft, 0);
        end
        check("idle_ax", ax, 270);

        // Default instance in AUTO: first tick moves +2/+2.
        run_a = 1'b1; manual_a = 1'b0;
        vsync_pulse;
        check("t1_aft", aft, 1);
        check("t1_ax", ax, 272);
        check("t1_ay", ay, 192);
        check("t1_cft", cft, 1);
        check("t1_cx", cx, 270);
        step;
        check("t1_aft_drop", aft, 0);

        for (int n = 2; n <= 136; n++) begin
            vsync_pulse;
            if (n == 2) check("div_t2_cx", cx, 270);
            if (n == 3) check("div_t3_cx", cx, 272);
            if (n == 5) begin
                check("div_t5_cx", cx, 272);
                check("div_t5_cft", cft, 1);
            end
            if (n == 6) begin
                check("div_t6_cx", cx, 274);
                check("div_t6_cy", cy, 194);
            end
            if (n == 134) begin
                check("a134_ax", ax, 538);
                check("a134_adx", adx, 1);
                check("a134_ay", ay, 302);
                check("a134_ady", ady, 0);
            end
            if (n == 135) begin
                check("a135_ax", ax, 540);
                check("a135_adx", adx, 0);
            end
            if (n == 136) begin
                check("a136_ax", ax, 538);
                check("a136_adx", adx, 0);
            end
            step;
        end

        // Small instance stayed stopped throughout.
        check("stop_bx", bx, 5);
        check("stop_by", by, 5);

        run_b = 1'b1; manual_b = 1'b1;
        press_b(1'b1, 1'b0, 1'b0, 1'b1);
        vsync_pulse;
        check("m1_bx", bx, 3);
        check("m1_by", by, 7);
        step;
        press_b(1'b1, 1'b0, 1'b0, 1'b0);
        vsync_pulse;
        check("m2_bx", bx, 1);
        step;
        press_b(1'b1, 1'b1, 1'b0, 1'b0);
        vsync_pulse;
        check("m3_both_bx", bx, 1);
        step;
        // Right button asserted in the tick cycle itself.
        vsync = 1'b0;
        step;
        step;
        vsync = 1'b1; br_b = 1'b1;
        step;
        br_b = 1'b0;
        check("m4_same_cycle_bx", bx, 3);
        step;
        vsync_pulse;
        check("m5_not_pending_bx", bx, 3);
        step;
        press_b(1'b1, 1'b0, 1'b0, 1'b0);
        vsync_pulse;
        check("m6_bx", bx, 1);
        step;
        press_b(1'b1, 1'b0, 1'b0, 1'b0);
        vsync_pulse;
        check("m7_clamp_bx", bx, 0);
        step;
        press_b(1'b1, 1'b0, 1'b0, 1'b0);
        vsync_pulse;
        check("m8_clamp_bx", bx, 0);
        check("m8_bdx", bdx, 1);
        check("m8_bdy", bdy, 1);
        step;

        manual_b = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            vsync_pulse;
            if (k == 6) begin
                check("b6_bx", bx, 11);
                check("b6_bdx", bdx, 0);
            end
            if (k == 11) begin
                check("b11_bx", bx, 1);
                check("b11_bdx", bdx, 0);
            end
            if (k == 12) begin
                check("b12_bx", bx, 0);
                check("b12_bdx", bdx, 1);
                check("b12_by", by, 8);
                check("b12_bdy", bdy, 1);
            end
            step;
        end

        // Reset across the edge where vsync rises: that edge must not update.
        vsync = 1'b0;
        step;
        step;
        rst = 1'b1; vsync = 1'b1;
        #1;
        check("rst_async_ax", ax, 270);
        check("rst_async_ay", ay, 190);
        step;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            check("post_rst_aft", aft, 0);
            check("post_rst_ax", ax, 270);
        end
        check("post_rst_ay", ay, 190);
        vsync_pulse;
        check("post_rst_t1_aft", aft, 1);
        check("post_rst_t1_ax", ax, 272);
        check("post_rst_t1_ay", ay, 192);
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
